// File: rtl/sysa_pkg.sv
// Shared definitions for the systolic-array datapath blocks.
package sysa_pkg;
    localparam int ACC_W = 16;
    localparam int N_DEF = 3;

    function automatic int row_w(input int n);
        return ACC_W * n;
    endfunction
endpackage

// File: rtl/sysa_fifo.sv
// Synchronous FIFO with a registered head word, push/pop, occupancy count and clear.
module sysa_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr, rd_next;
    logic [AW:0]      cnt_next;
    logic             do_push, do_pop;
    logic [WIDTH-1:0] head_next;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push  = push && (!full || do_pop);
    assign rd_next  = rd_ptr + AW'(do_pop);
    assign cnt_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);

    // The head register must see a word written this edge when it lands in the head slot.
    always_comb begin
        head_next = dout;
        if (do_push && (wr_ptr == rd_next))
            head_next = din;
        else if (cnt_next != '0)
            head_next = mem[rd_next];
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_next;
            count  <= cnt_next;
            dout   <= head_next;
        end
    end
endmodule

// File: rtl/sysa_drain.sv
// Bottom-edge collector: de-skews the array's column streams into whole rows and buffers them.
module sysa_drain
    import sysa_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int LAT   = 3,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       issue,
    input  logic [row_w(N)-1:0]        col_in,
    input  logic                       clear,
    output logic [row_w(N)-1:0]        row_data,
    output logic                       row_valid,
    input  logic                       row_ready,
    output logic [$clog2(DEPTH):0]     fill,
    output logic                       ovf
);
    localparam int SR_LEN = LAT + N - 1;
    localparam int RW     = row_w(N);

    logic [SR_LEN-1:0] vld_sr;
    logic [RW-1:0]     aligned;
    logic              row_done, full, empty, drop;

    // One bit per in-flight row; its exit marks the edge where every column is aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_sr <= '0;
        else if (clear)
            vld_sr <= '0;
        else if (en)
            vld_sr <= {vld_sr[SR_LEN-2:0], issue};
    end

    genvar j;
    for (j = 0; j < N; j++) begin : g_col
        if (j == N - 1) begin : g_direct
            assign aligned[j*ACC_W +: ACC_W] = col_in[j*ACC_W +: ACC_W];
        end else begin : g_delay
            localparam int D = N - 1 - j;
            logic [ACC_W-1:0] line [D];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < D; s++)
                        line[s] <= '0;
                end else if (en) begin
                    line[0] <= col_in[j*ACC_W +: ACC_W];
                    for (int s = 1; s < D; s++)
                        line[s] <= line[s-1];
                end
            end

            assign aligned[j*ACC_W +: ACC_W] = line[D-1];
        end
    end

    assign row_done  = en && vld_sr[SR_LEN-1] && !clear;
    assign drop      = row_done && full && !(row_ready && !empty);
    assign row_valid = !empty;

    sysa_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (row_done),
        .din   (aligned),
        .pop   (row_ready),
        .dout  (row_data),
        .full  (full),
        .empty (empty),
        .count (fill)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf <= 1'b0;
        else if (clear)
            ovf <= 1'b0;
        else if (drop)
            ovf <= 1'b1;
    end
endmodule
